// File: rtl/mac_pkg.sv
// Shared types and encodings for the MAC neuron stream feeder.
package mac_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DRAIN
    } feeder_state_t;

    localparam logic [1:0] LD_INPUT  = 2'd0;
    localparam logic [1:0] LD_WEIGHT = 2'd1;
    localparam logic [1:0] LD_BIAS   = 2'd2;

endpackage

// File: rtl/mac_stream_feeder_if.sv
// Stream bundle between the feeder (master) and the MAC neuron (slave).
interface mac_stream_feeder_if #(
    parameter int DATA_W = mac_pkg::DATA_W_DEF
);
    logic              i_TVALID, k_TVALID, b_TVALID;
    logic [DATA_W-1:0] i_TDATA, k_TDATA, b_TDATA;
    logic              i_TREADY, k_TREADY, b_TREADY;
    logic              new_o;
    logic              o_TVALID, o_TREADY;
    logic [DATA_W-1:0] o_TDATA;

    modport master (
        output i_TVALID, i_TDATA, k_TVALID, k_TDATA, b_TVALID, b_TDATA, new_o, o_TREADY,
        input  i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TDATA
    );

    modport slave (
        input  i_TVALID, i_TDATA, k_TVALID, k_TDATA, b_TVALID, b_TDATA, new_o, o_TREADY,
        output i_TREADY, k_TREADY, b_TREADY, o_TVALID, o_TDATA
    );
endinterface

// File: rtl/mac_feeder_buf.sv
// DEPTH x DATA_W vector buffer: one synchronous write port, one combinational read port.
module mac_feeder_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset; contents are only meaningful after a host load, and resetting it would cost a mux per bit.
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/mac_stream_feeder.sv
// Streams preloaded i/k vectors and a bias into the MAC neuron and captures its result.
// Define MAC_STREAM_FEEDER_TIMEOUT_EN to abandon a result wait after TIMEOUT_CYC cycles.
module mac_stream_feeder
    import mac_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = $clog2(DEPTH),
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ld_valid,
    input  logic [1:0]          ld_sel,
    input  logic [ADDR_W-1:0]   ld_addr,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                start,
    input  logic [ADDR_W:0]     len,
    mac_stream_feeder_if.master nrn,
    output logic                busy,
    output logic                done,
    output logic [DATA_W-1:0]   result_data,
    output logic                err
);
    feeder_state_t     state_q, state_d;
    logic [ADDR_W:0]   idx_q, idx_d, len_q, len_d;
    logic              b_sent_q, b_sent_d;
    logic              done_q, done_d, err_q, err_d;
    logic [DATA_W-1:0] result_q, result_d, bias_q;
    logic [DATA_W-1:0] ibuf_rd, kbuf_rd;
    logic              ld_idle, len_ok, pair_fire, b_fire;

    assign ld_idle = ld_valid && (state_q == IDLE);
    assign len_ok  = (len != '0) && (len <= (ADDR_W+1)'(DEPTH));

    mac_feeder_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ibuf (
        .clk(clk), .we_i(ld_idle && (ld_sel == LD_INPUT)), .waddr_i(ld_addr),
        .wdata_i(ld_data), .raddr_i(idx_q[ADDR_W-1:0]), .rdata_o(ibuf_rd)
    );

    mac_feeder_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_kbuf (
        .clk(clk), .we_i(ld_idle && (ld_sel == LD_WEIGHT)), .waddr_i(ld_addr),
        .wdata_i(ld_data), .raddr_i(idx_q[ADDR_W-1:0]), .rdata_o(kbuf_rd)
    );

    // Bias is configuration storage like the buffers, so it is not reset either.
    always_ff @(posedge clk) begin
        if (ld_idle && (ld_sel == LD_BIAS)) bias_q <= ld_data;
    end

    assign nrn.i_TVALID = (state_q == STREAM) && (idx_q < len_q);
    assign nrn.k_TVALID = nrn.i_TVALID;
    assign nrn.i_TDATA  = ibuf_rd;
    assign nrn.k_TDATA  = kbuf_rd;
    assign nrn.b_TVALID = (state_q == STREAM) && !b_sent_q;
    assign nrn.b_TDATA  = bias_q;
    assign nrn.new_o    = (state_q == STREAM);
    assign nrn.o_TREADY = (state_q == DRAIN);

    // i and k move as one pair: both readies must be high together.
    assign pair_fire = nrn.i_TVALID && nrn.i_TREADY && nrn.k_TREADY;
    assign b_fire    = nrn.b_TVALID && nrn.b_TREADY;

    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign result_data = result_q;

`ifdef MAC_STREAM_FEEDER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYC;
`endif

    always_comb begin
        // NOTE: every next-state value gets its default first, so no path through the case can infer a latch.
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        b_sent_d = b_sent_q;
        result_d = result_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef MAC_STREAM_FEEDER_TIMEOUT_EN
        tmo_d    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (len_ok) begin
                        len_d    = len;
                        idx_d    = '0;
                        b_sent_d = 1'b0;
                        state_d  = STREAM;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (pair_fire) idx_d = idx_q + 1'b1;
                if (b_fire) b_sent_d = 1'b1;
                if ((idx_d == len_q) && b_sent_d) state_d = DRAIN;
            end
            DRAIN: begin
                if (nrn.o_TVALID) begin
                    result_d = nrn.o_TDATA;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
`ifdef MAC_STREAM_FEEDER_TIMEOUT_EN
                else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register updates from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            b_sent_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            b_sent_q <= b_sent_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

`ifdef MAC_STREAM_FEEDER_TIMEOUT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) tmo_q <= '0;
        else       tmo_q <= tmo_d;
    end
`endif
endmodule
